seq_frame_sync_ctrl: RTL and testbench

Frame synchroniser and sequencer for a bit-serial receive line, built around the team's consecutive-ones run counter (counter_seq_en).
- Hunts for a preamble of at least PRE_LEN consecutive 1s, followed by a 0 start bit.
- Shifts in DATA_W payload bits LSB-first, then checks a 1 stop bit.
- Aborts the frame when the ones-run inside the payload reaches ABORT_LEN.
- Sits between the bit sampler (one qualified bit per i_bit_en strobe) and the byte-level consumer.

---
 rtl/seq_frame_pkg.sv | 22 ++
 rtl/counter_seq_en.sv | 33 +++
 rtl/seq_frame_sync_ctrl.sv | 116 +++++++++++
 tb/tb_seq_frame_sync_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_frame_pkg.sv
// Shared types and default constants for the serial frame synchroniser.
package seq_frame_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } frame_state_e;

  localparam int DEF_CNT_W     = 4;
  localparam int DEF_PRE_LEN   = 6;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ABORT_LEN = 7;

  // Bit-index width; a one-bit payload still needs a one-bit index register.
  function automatic int idxWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_IDX_W = idxWidth(DEF_DATA_W);

endpackage

// File: rtl/counter_seq_en.sv
// Consecutive-ones run counter: counts qualified 1 bits, clears on a 0,
// saturates at LIMIT so long idle lines never wrap back to a short run.
module counter_seq_en #(
  parameter int WIDTH = 4,
  parameter int LIMIT = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             dat_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] LIM = LIMIT[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q;

  // Advance the run on each qualified bit; hold while the enable is low.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (!dat_i) begin
        cnt_q <= '0;
      end else if (cnt_q < LIM) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_frame_sync_ctrl.sv
// Frame synchroniser: hunts a ones preamble, takes a 0 start bit, shifts in
// an LSB-first payload, checks a 1 stop bit and aborts on long ones runs.
module seq_frame_sync_ctrl
  import seq_frame_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PRE_LEN   = DEF_PRE_LEN,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ABORT_LEN = DEF_ABORT_LEN
) (
  input  logic              clk,
  input  logic              i_sclr,
  input  logic              i_bit_en,
  input  logic              i_dat,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ferr,
  output logic              o_abort,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_run
);

  localparam int IW = idxWidth(DATA_W);
  localparam logic [CNT_W-1:0] PRE_TH   = PRE_LEN[CNT_W-1:0];
  localparam logic [CNT_W:0]   ABORT_TH = ABORT_LEN[CNT_W:0];
  localparam logic [IW-1:0]    LAST_IDX = IW'(DATA_W - 1);

  frame_state_e      state_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              abort_q;
  logic              busy_q;
  logic [CNT_W-1:0]  runPrev;
  logic              abortHit;

  counter_seq_en #(
    .WIDTH(CNT_W),
    .LIMIT((1 << CNT_W) - 1)
  ) u_run (
    .clk  (clk),
    .clr_i(i_sclr),
    .en_i (i_bit_en),
    .dat_i(i_dat),
    .cnt_o(runPrev)
  );

  // The counter still holds the pre-bit value here, so a 1 pushes it to run+1.
  assign abortHit = i_dat && (({1'b0, runPrev} + 1'b1) >= ABORT_TH);

  // Frame FSM with shift register and registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q <= HUNT;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (i_bit_en && !i_dat && (runPrev >= PRE_TH)) begin
            state_q <= DATA;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          if (i_bit_en) begin
            shift_q <= {i_dat, shift_q[DATA_W-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (abortHit) begin
              abort_q <= 1'b1;
              state_q <= HUNT;
              busy_q  <= 1'b0;
            end else if (idx_q == LAST_IDX) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (i_bit_en) begin
            if (i_dat) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= HUNT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ferr  = ferr_q;
  assign o_abort = abort_q;
  assign o_busy  = busy_q;
  assign o_run   = runPrev;

endmodule

// File: tb/tb_seq_frame_sync_ctrl.sv
// Self-checking bench: directed frames plus randomized frames, each bit
// compared against a bit-stream reference model.
module tb_seq_frame_sync_ctrl;

  logic       clk = 1'b0;
  logic       i_sclr;
  logic       i_bit_en;
  logic       i_dat;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ferr;
  logic       o_abort;
  logic       o_busy;
  logic [3:0] o_run;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: run length, phase (0 idle, 1 payload, 2 stop), payload bits.
  int mRun;
  int mMode;
  bit mQ[$];
  int expData;
  int expValid;
  int expFerr;
  int expAbort;

  seq_frame_sync_ctrl dut (
    .clk     (clk),
    .i_sclr  (i_sclr),
    .i_bit_en(i_bit_en),
    .i_dat   (i_dat),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ferr  (o_ferr),
    .o_abort (o_abort),
    .o_busy  (o_busy),
    .o_run   (o_run)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCount++;
    if (obs == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    mRun = 0;
    mMode = 0;
    mQ.delete();
    expData = 0;
    expValid = 0;
    expFerr = 0;
    expAbort = 0;
  endtask

  // Apply one qualified bit to the model using the frame rules directly.
  task automatic stepModel(input bit d);
    int runPrev;
    int v;
    runPrev  = mRun;
    expValid = 0;
    expFerr  = 0;
    expAbort = 0;
    mRun = d ? ((mRun < 15) ? mRun + 1 : 15) : 0;
    case (mMode)
      0: begin
        if (!d && runPrev >= 6) begin
          mMode = 1;
          mQ.delete();
        end
      end
      1: begin
        mQ.push_back(d);
        if (d && runPrev + 1 >= 7) begin
          expAbort = 1;
          mMode = 0;
        end else if (mQ.size() == 8) begin
          mMode = 2;
        end
      end
      default: begin
        if (d) begin
          v = 0;
          for (int i = 0; i < 8; i++) v = v | (int'(mQ[i]) << i);
          expData  = v;
          expValid = 1;
        end else begin
          expFerr = 1;
        end
        mMode = 0;
      end
    endcase
  endtask

  task automatic compareAll(input string ctx);
    checkOutput({ctx, ".valid"}, int'(o_valid), expValid);
    checkOutput({ctx, ".ferr"},  int'(o_ferr),  expFerr);
    checkOutput({ctx, ".abort"}, int'(o_abort), expAbort);
    checkOutput({ctx, ".busy"},  int'(o_busy),  (mMode != 0) ? 1 : 0);
    checkOutput({ctx, ".run"},   int'(o_run),   mRun);
    checkOutput({ctx, ".data"},  int'(o_data),  expData);
  endtask

  // Drive one qualified bit, then `gap` idle cycles with junk on i_dat.
  task automatic applyStimulus(input bit d, input int gap);
    @(negedge clk);
    i_bit_en = 1'b1;
    i_dat    = d;
    @(posedge clk);
    #1;
    stepModel(d);
    compareAll("bit");
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      i_bit_en = 1'b0;
      i_dat    = 1'($urandom);
      @(posedge clk);
      #1;
      expValid = 0;
      expFerr  = 0;
      expAbort = 0;
      compareAll("gap");
    end
    @(negedge clk);
    i_bit_en = 1'b0;
  endtask

  task automatic sendFrame(input int pre, input int payload, input bit stopBit, input int gap);
    for (int i = 0; i < pre; i++) applyStimulus(1'b1, gap);
    applyStimulus(1'b0, gap);
    for (int i = 0; i < 8; i++) applyStimulus(1'((payload >> i) & 1), gap);
    applyStimulus(stopBit, gap);
  endtask

  // Two-cycle reset while the line keeps presenting the given bit.
  task automatic resetDut(input bit en, input bit d);
    @(negedge clk);
    i_sclr   = 1'b1;
    i_bit_en = en;
    i_dat    = d;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    compareAll("reset");
    @(negedge clk);
    i_sclr   = 1'b0;
    i_bit_en = 1'b0;
  endtask

  initial begin
    i_sclr   = 1'b0;
    i_bit_en = 1'b0;
    i_dat    = 1'b0;
    modelReset();

    resetDut(1'b0, 1'b0);

    // Good frame 0xA5.
    sendFrame(6, 8'hA5, 1'b1, 0);

    // Short preamble after a clearing 0, then a qualifying one.
    applyStimulus(1'b0, 0);
    sendFrame(5, 8'hA5, 1'b1, 0);
    applyStimulus(1'b0, 0);
    sendFrame(6, 8'hA5, 1'b1, 0);

    // Framing error keeps the previous data.
    applyStimulus(1'b0, 0);
    sendFrame(6, 8'h3C, 1'b0, 0);

    // Abort on 0xFF payload, ones continue straight into a new preamble.
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'((8'h12 >> i) & 1), 0);
    applyStimulus(1'b1, 0);

    // Gapped frame 0x5A.
    applyStimulus(1'b0, 0);
    sendFrame(6, 8'h5A, 1'b1, 3);

    // Reset mid-frame while a bit is presented; reset must win silently.
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'((8'h5A >> i) & 1), 0);
    resetDut(1'b1, 1'b1);

    // Saturated preamble.
    sendFrame(20, 8'h81, 1'b1, 0);

    // Randomized frames with varied preambles, stop bits, gaps and noise.
    for (int n = 0; n < 80; n++) begin
      int pre;
      int gap;
      pre = $urandom_range(3, 12);
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, gap);
      sendFrame(pre, int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), gap);
      for (int k = $urandom_range(0, 3); k > 0; k--) applyStimulus(1'($urandom), 0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
